// File: rtl/uart_rx_bank8.sv
// uart_rx_bank8: 8N1 UART receiver that stores good bytes in an 8-slot bank.
//
// Bytes land in the slot pointed to by wr_ptr, which then advances (7 wraps to 0).
// Each slot has a valid flag. Writing into a slot whose flag is still set raises overrun.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rxd        asynchronous serial input, idle high, LSB first
//   clr        synchronous clear of valid flags and write pointer
//   y0..y7     received byte bank, slots 0..7
//   valid      per-slot "holds an unread byte" flags
//   wr_ptr     slot that receives the next good byte
//   byte_done  one-cycle pulse on each committed byte
//   frame_err  one-cycle pulse when the stop bit samples low
//   overrun    one-cycle pulse when a commit overwrites a valid slot
module uart_rx_bank8 #(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   input  logic       clr,
   output logic [7:0] y0,
   output logic [7:0] y1,
   output logic [7:0] y2,
   output logic [7:0] y3,
   output logic [7:0] y4,
   output logic [7:0] y5,
   output logic [7:0] y6,
   output logic [7:0] y7,
   output logic [7:0] valid,
   output logic [2:0] wr_ptr,
   output logic       byte_done,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CW    = 16;
   localparam int unsigned NSLOT = 8;

   // Counter reload values: the sample is taken when the down-counter hits zero
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   logic [1:0]    sync_q;
   logic          rx_s;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [2:0]    bitn, bitn_d;
   logic [7:0]    shreg, shreg_d;

   logic          commit_c;
   logic          ferr_c;
   logic [2:0]    slot_c;
   logic [7:0]    base_valid_c;

   logic [7:0]    bank [NSLOT];

   // Two-flop synchronizer; resets to the idle (high) line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxd};
      end
   end

   assign rx_s = sync_q[1];

   // Receiver state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         bitn  <= 3'd0;
         shreg <= 8'h00;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         bitn  <= bitn_d;
         shreg <= shreg_d;
      end
   end

   // Next-state logic; the baud counter counts down and the line is sampled at zero
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      bitn_d   = bitn;
      shreg_d  = shreg;
      commit_c = 1'b0;
      ferr_c   = 1'b0;

      unique case (state)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = HALF_LOAD;
               bitn_d  = 3'd0;
            end
         end

         START: begin
            if (cnt == '0) begin
               if (!rx_s) begin
                  state_d = DATA;
                  cnt_d   = FULL_LOAD;
               end else begin
                  // A line that came back high is treated as a glitch
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end

         DATA: begin
            if (cnt == '0) begin
               shreg_d = {rx_s, shreg[7:1]};
               cnt_d   = FULL_LOAD;
               if (bitn == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bitn_d = bitn + 3'd1;
               end
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end

         STOP: begin
            if (cnt == '0) begin
               if (rx_s) begin
                  commit_c = 1'b1;
                  state_d  = IDLE;
               end else begin
                  ferr_c  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end

         WAIT_HIGH: begin
            // Stay here until the line idles, so a held break is not read as a start bit
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A clr on the commit cycle restarts the bank, so the byte goes to slot 0
   always_comb begin
      slot_c       = clr ? 3'd0 : wr_ptr;
      base_valid_c = clr ? 8'h00 : valid;
   end

   // Byte bank, flags, pointer and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NSLOT; i++) begin
            bank[i] <= 8'h00;
         end
         valid     <= 8'h00;
         wr_ptr    <= 3'd0;
         byte_done <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         byte_done <= commit_c;
         frame_err <= ferr_c;
         overrun   <= 1'b0;
         if (commit_c) begin
            bank[slot_c] <= shreg;
            valid        <= base_valid_c | (8'h01 << slot_c);
            wr_ptr       <= slot_c + 3'd1;
            overrun      <= !clr && valid[wr_ptr];
         end else if (clr) begin
            valid  <= 8'h00;
            wr_ptr <= 3'd0;
         end
      end
   end

   assign y0 = bank[0];
   assign y1 = bank[1];
   assign y2 = bank[2];
   assign y3 = bank[3];
   assign y4 = bank[4];
   assign y5 = bank[5];
   assign y6 = bank[6];
   assign y7 = bank[7];

endmodule

// File: tb/tb_uart_rx_bank8.sv
// Testbench for uart_rx_bank8 at BAUD_DIV = 16.
// A frame-level model predicts the bank contents and pulses; a negedge process compares every cycle.
module tb_uart_rx_bank8;

   localparam int unsigned BD = 16;
   // Cycles from driving the start-bit edge to the commit edge:
   // 2 synchronizer + 1 idle detect + BD/2 start + 8*BD data + BD stop
   localparam int COMMIT_LAT = 2 + 1 + 8 + 8 * 16 + 16;
   localparam int FRAME_CYC  = 10 * 16;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd   = 1'b1;
   logic       clr   = 1'b0;
   logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [7:0] valid;
   logic [2:0] wr_ptr;
   logic       byte_done, frame_err, overrun;

   uart_rx_bank8 #(.BAUD_DIV(BD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .clr       (clr),
      .y0        (y0),
      .y1        (y1),
      .y2        (y2),
      .y3        (y3),
      .y4        (y4),
      .y5        (y5),
      .y6        (y6),
      .y7        (y7),
      .valid     (valid),
      .wr_ptr    (wr_ptr),
      .byte_done (byte_done),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- frame-level model ----------------
   typedef struct {
      int         t;
      bit         good;
      logic [7:0] b;
   } ev_t;

   ev_t        evq[$];
   ev_t        cur_ev;
   int         cyc = 0;
   logic [7:0] m_y [8] = '{default: 8'h00};
   logic [7:0] m_valid = 8'h00;
   logic [2:0] m_wp    = 3'd0;
   logic [2:0] m_slot;
   bit         m_bd = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

   int n_bd = 0, n_fe = 0, n_ov = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_y[i] = 8'h00;
         m_valid = 8'h00;
         m_wp    = 3'd0;
         m_bd    = 1'b0;
         m_fe    = 1'b0;
         m_ov    = 1'b0;
         evq.delete();
      end else begin
         cyc++;
         m_bd = 1'b0;
         m_fe = 1'b0;
         m_ov = 1'b0;
         if (evq.size() > 0 && evq[0].t == cyc) begin
            cur_ev = evq.pop_front();
            if (cur_ev.good) begin
               if (clr) begin
                  m_valid = 8'h00;
                  m_slot  = 3'd0;
               end else begin
                  m_slot = m_wp;
               end
               m_ov             = m_valid[m_slot];
               m_y[m_slot]      = cur_ev.b;
               m_valid[m_slot]  = 1'b1;
               m_wp             = m_slot + 3'd1;
               m_bd             = 1'b1;
            end else begin
               m_fe = 1'b1;
               if (clr) begin
                  m_valid = 8'h00;
                  m_wp    = 3'd0;
               end
            end
         end else if (clr) begin
            m_valid = 8'h00;
            m_wp    = 3'd0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("bank", {y7, y6, y5, y4, y3, y2, y1, y0},
             {m_y[7], m_y[6], m_y[5], m_y[4], m_y[3], m_y[2], m_y[1], m_y[0]});
         chk("valid", 64'(valid), 64'(m_valid));
         chk("wr_ptr", 64'(wr_ptr), 64'(m_wp));
         chk("pulses", 64'({byte_done, frame_err, overrun}), 64'({m_bd, m_fe, m_ov}));
         if (byte_done) n_bd++;
         if (frame_err) n_fe++;
         if (overrun)   n_ov++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit clr_at_commit);
      ev_t e;
      int  bi;
      e.t    = cyc + COMMIT_LAT;
      e.good = stop_ok;
      e.b    = b;
      evq.push_back(e);
      for (int k = 0; k < FRAME_CYC; k++) begin
         bi = k / 16;
         if (bi == 0)       rxd = 1'b0;
         else if (bi <= 8)  rxd = b[bi-1];
         else               rxd = stop_ok;
         // clr is high in the stop-sample cycle, so it lands on the commit edge
         clr = clr_at_commit && (k == COMMIT_LAT - 1);
         tick(1);
      end
      clr = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      tick(1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bank"}, {y7, y6, y5, y4, y3, y2, y1, y0}, 64'h0);
      chk({tag, "_valid"}, 64'(valid), 64'h00);
      chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'h0);
      chk({tag, "_pulses"}, 64'({byte_done, frame_err, overrun}), 64'h0);
   endtask

   int         bd0, fe0, ov0;
   logic [7:0] exp_y [8];
   logic [7:0] act_y [8];
   logic [7:0] pbyte;

   initial begin
      // Reset
      tick(3);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      tick(5);

      // Single good byte
      bd0 = n_bd;
      send_frame(8'hA5, 1'b1, 1'b0);
      tick(5);
      chk("a5_y0", 64'(y0), 64'hA5);
      chk("a5_valid", 64'(valid), 64'h01);
      chk("a5_wr_ptr", 64'(wr_ptr), 64'h1);
      chk("a5_byte_done_cnt", 64'(n_bd - bd0), 64'd1);

      // Nine bytes, the ninth wraps onto slot 0
      do_clr();
      ov0 = n_ov;
      bd0 = n_bd;
      for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
      tick(5);
      exp_y = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      act_y = '{y0, y1, y2, y3, y4, y5, y6, y7};
      for (int i = 0; i < 8; i++) chk($sformatf("wrap_y%0d", i), 64'(act_y[i]), 64'(exp_y[i]));
      chk("wrap_valid", 64'(valid), 64'hFF);
      chk("wrap_wr_ptr", 64'(wr_ptr), 64'h1);
      chk("wrap_overrun_cnt", 64'(n_ov - ov0), 64'd1);
      chk("wrap_byte_done_cnt", 64'(n_bd - bd0), 64'd9);

      // Framing error, held break, then a good byte
      do_clr();
      fe0 = n_fe;
      bd0 = n_bd;
      send_frame(8'h3C, 1'b0, 1'b0);
      rxd = 1'b0;
      tick(40);
      rxd = 1'b1;
      tick(20);
      send_frame(8'h5A, 1'b1, 1'b0);
      tick(5);
      chk("ferr_cnt", 64'(n_fe - fe0), 64'd1);
      chk("ferr_byte_done_cnt", 64'(n_bd - bd0), 64'd1);
      chk("ferr_y0", 64'(y0), 64'h5A);
      chk("ferr_valid", 64'(valid), 64'h01);

      // Short low glitch is rejected
      bd0 = n_bd;
      fe0 = n_fe;
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      tick(40);
      chk("glitch_valid", 64'(valid), 64'h01);
      chk("glitch_pulse_cnt", 64'((n_bd - bd0) + (n_fe - fe0)), 64'd0);

      // clr coincident with the third commit
      do_clr();
      ov0 = n_ov;
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b1);
      tick(5);
      chk("clrc_y0", 64'(y0), 64'h33);
      chk("clrc_y1", 64'(y1), 64'h22);
      chk("clrc_valid", 64'(valid), 64'h01);
      chk("clrc_wr_ptr", 64'(wr_ptr), 64'h1);
      chk("clrc_overrun_cnt", 64'(n_ov - ov0), 64'd0);

      // Reset in the middle of data bit 4, then a fresh frame
      do_clr();
      bd0   = n_bd;
      pbyte = 8'hC3;
      rxd   = 1'b0;
      tick(16);
      for (int i = 0; i < 4; i++) begin
         rxd = pbyte[i];
         tick(16);
      end
      rxd = pbyte[4];
      tick(8);
      rst_n = 1'b0;
      rxd   = 1'b1;
      #1;
      chk_reset_vals("midreset");
      tick(3);
      rst_n = 1'b1;
      tick(10);
      send_frame(8'h81, 1'b1, 1'b0);
      tick(5);
      chk("rst_y0", 64'(y0), 64'h81);
      chk("rst_valid", 64'(valid), 64'h01);
      chk("rst_byte_done_cnt", 64'(n_bd - bd0), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_bank8.md
UART_RX_BANK8 -- requirements
Module: uart_rx_bank8

Interface
REQ-001 Parameter: BAUD_DIV, default 868, clock cycles per serial bit period (legal range 4..65535).
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port: rxd  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-005 Port: clr  input  1  synchronous clear of the byte-bank valid flags and write pointer.
REQ-006 Port: y0..y7  output  8 each  received byte bank, slot 0..7, registered.
REQ-007 Port: valid  output  8  bit i set = slot i holds an unread byte since the last clr.
REQ-008 Port: wr_ptr  output  3  slot that receives the next good byte.
REQ-009 Port: byte_done  output  1  one-cycle pulse when a good byte is written.
REQ-010 Port: frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 Port: overrun  output  1  one-cycle pulse when a good byte overwrites a slot whose valid bit is set.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer before any use; all timings below are from the synchronized signal.
REQ-013 FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE -> START on synchronized rxd sampled 0; bit counter cleared, baud counter loaded.
REQ-015 START: after BAUD_DIV/2 cycles (integer division) rxd resampled; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-016 DATA: 8 samples taken every BAUD_DIV cycles from the start-bit midpoint, shifted in LSB first; after the 8th -> STOP.
REQ-017 STOP: sample BAUD_DIV cycles after the 8th data sample; 1 -> commit byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE on first cycle rxd sampled 1; no new frame accepted while rxd is low.
REQ-019 Commit: y[wr_ptr] <= byte, valid[wr_ptr] <= 1, wr_ptr <= wr_ptr+1 modulo 8 (7 wraps to 0), byte_done = 1 for exactly that cycle.
REQ-020 Commit into a slot with valid already 1: data overwritten, overrun = 1 same cycle as byte_done.
REQ-021 clr alone: valid <= 0, wr_ptr <= 0; y0..y7 unchanged; FSM unaffected (frame in flight continues).
REQ-022 clr coincident with commit: byte written to slot 0, valid <= 8'h01, wr_ptr <= 1, byte_done = 1, overrun = 0.
REQ-023 Latency: byte_done asserts the cycle after the stop-bit sample; y/valid/wr_ptr updated on the same edge.
REQ-024 byte_done, frame_err, overrun SHALL never be high more than one consecutive cycle; frame_err and byte_done are mutually exclusive.
REQ-025 Baud counter width SHALL be 16 bits; no counter overflow at BAUD_DIV = 65535.

Reset
REQ-026 On rst_n low, immediately: FSM = IDLE, synchronizer flops = 1, y0..y7 = 8'h00, valid = 8'h00, wr_ptr = 3'd0, byte_done = frame_err = overrun = 0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no commit and no pulse; first frame after release is received normally.
REQ-028 Release of rst_n is synchronous to clk externally; rxd low at release is treated as a start bit.

Verification (BAUD_DIV = 16)
REQ-029 Send 0xA5 with good stop -> y0 = 8'hA5, valid = 8'h01, wr_ptr = 1, one byte_done pulse.
REQ-030 Send 9 bytes 0x00..0x08 without clr -> y0 = 8'h08, y1..y7 = 8'h01..8'h07, valid = 8'hFF, wr_ptr = 1, overrun pulses once (9th byte).
REQ-031 Send 0x3C with stop bit low then hold rxd low 40 cycles, then 0x5A -> frame_err once, y0 = 8'h5A, valid = 8'h01.
REQ-032 Low glitch on rxd of 4 cycles -> no state leaves IDLE past START, no pulses, valid unchanged.
REQ-033 Assert clr on the exact byte_done cycle of the 3rd byte -> that byte in y0, valid = 8'h01, wr_ptr = 1, overrun = 0.
REQ-034 Pull rst_n low during DATA bit 4 of a frame, release, send 0x81 -> y0 = 8'h81, valid = 8'h01, only one byte_done total.
